// File: rtl/adc_frame_capture.sv
// rtl/adc_frame_capture.sv - single-channel ADC frame capture feeding an FFT stage
module adc_frame_capture #(
  parameter int FRAME_LEN  = 256,
  parameter int SAMPLE_DIV = 1000
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic [11:0] CH0,
  input  logic [11:0] CH1,
  input  logic [11:0] CH2,
  input  logic [11:0] CH3,
  input  logic [11:0] CH4,
  input  logic [11:0] CH5,
  input  logic [11:0] CH6,
  input  logic [11:0] CH7,
  input  logic        enable,
  input  logic [2:0]  ch_sel,
  output logic [11:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        busy,
  output logic        overrun
);

  localparam int AW = $clog2(FRAME_LEN);
  localparam int TW = $clog2(SAMPLE_DIV);
  localparam logic [AW-1:0] LAST_IDX = AW'(FRAME_LEN - 1);
  localparam logic [TW-1:0] TICK_CNT = TW'(SAMPLE_DIV - 1);

  typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

  state_t          state;
  logic [TW-1:0]   timer;
  logic            tick;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   rd_addr;
  logic            overrun_q;
  logic [11:0]     sample_raw;
  logic [11:0]     sample_conv;
  logic [11:0]     mem [FRAME_LEN];
  logic [11:0]     mem_q;
  logic            transfer;

  // A tick only exists while capturing is enabled; the timer is parked at 0 otherwise.
  assign tick = enable && (timer == TICK_CNT);

  // Sample-rate divider: 0..SAMPLE_DIV-1 while enabled, cleared while disabled.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET)
      timer <= '0;
    else if (!enable || tick)
      timer <= '0;
    else
      timer <= timer + 1'b1;
  end

  // Channel mux; only the value present on a tick cycle is ever stored.
  always_comb begin
    sample_raw = CH7;
    case (ch_sel)
      3'd0: sample_raw = CH0;
      3'd1: sample_raw = CH1;
      3'd2: sample_raw = CH2;
      3'd3: sample_raw = CH3;
      3'd4: sample_raw = CH4;
      3'd5: sample_raw = CH5;
      3'd6: sample_raw = CH6;
      3'd7: sample_raw = CH7;
      default: sample_raw = CH7;
    endcase
  end

  // Offset-binary to two's complement is a flip of the MSB.
  assign sample_conv = {~sample_raw[11], sample_raw[10:0]};

  assign out_valid = (state == DRAIN);
  assign transfer  = out_valid && out_ready;
  assign out_last  = out_valid && (rd_ptr == LAST_IDX);
  assign out_data  = out_valid ? mem_q : 12'h000;
  assign busy      = (state != IDLE);
  assign overrun   = overrun_q;

  // Read one entry ahead on a transfer so the registered RAM output always holds the presented sample.
  always_comb begin
    rd_addr = rd_ptr;
    if (transfer)
      rd_addr = rd_ptr + 1'b1;
  end

  // Frame buffer: one write port from the capture side, one registered read port to the drain side.
  always_ff @(posedge CLOCK) begin
    if (state == FILL && tick)
      mem[wr_ptr] <= sample_conv;
    mem_q <= mem[rd_addr];
  end

  // Capture/drain control: fill a whole frame, then hand it out before capturing again.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overrun_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          rd_ptr <= '0;
          if (enable) begin
            state     <= FILL;
            wr_ptr    <= '0;
            overrun_q <= 1'b0;
          end
        end
        FILL: begin
          rd_ptr <= '0;
          if (!enable) begin
            state  <= IDLE;
            wr_ptr <= '0;
          end else if (tick) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (wr_ptr == LAST_IDX)
              state <= DRAIN;
          end
        end
        DRAIN: begin
          if (tick)
            overrun_q <= 1'b1;
          if (out_ready) begin
            rd_ptr <= rd_ptr + 1'b1;
            if (rd_ptr == LAST_IDX)
              state <= enable ? FILL : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_frame_capture.sv
// tb/tb_adc_frame_capture.sv - directed bench for adc_frame_capture (SAMPLE_DIV=4, FRAME_LEN=8)
module tb_adc_frame_capture;

  logic        clk;
  logic        rst;
  logic [11:0] ch_in [8];
  logic        enable;
  logic [2:0]  ch_sel;
  logic [11:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        busy;
  logic        overrun;

  int vectors;
  int miscompares;

  adc_frame_capture #(.FRAME_LEN(8), .SAMPLE_DIV(4)) dut (
    .CLOCK     (clk),
    .RESET     (rst),
    .CH0       (ch_in[0]),
    .CH1       (ch_in[1]),
    .CH2       (ch_in[2]),
    .CH3       (ch_in[3]),
    .CH4       (ch_in[4]),
    .CH5       (ch_in[5]),
    .CH6       (ch_in[6]),
    .CH7       (ch_in[7]),
    .enable    (enable),
    .ch_sel    (ch_sel),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk12(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  // 32 cycles of capture starting at a negedge; ticks land on cycles 3,7,...,31.
  // Off-tick cycles point ch_sel elsewhere and scribble on the selected channel.
  task automatic fill_frame(input logic [2:0] ch, input logic [11:0] base,
                            input logic [11:0] step, input logic from_idle);
    logic [2:0] other;
    other = ch + 3'd1;
    for (int c = 0; c < 32; c++) begin
      enable = 1'b1;
      if (c % 4 == 3) begin
        ch_sel    = ch;
        ch_in[ch] = base + step * 12'(c / 4);
      end else begin
        ch_sel       = other;
        ch_in[ch]    = 12'h5A5;
        ch_in[other] = 12'h3C3;
      end
      chk1("fill_valid", out_valid, 1'b0);
      chk1("fill_busy", busy, from_idle ? (c != 0) : 1'b1);
      @(negedge clk);
    end
  endtask

  // Consume n samples with out_ready high, expecting exp0 + step*i.
  task automatic drain_frame(input logic [11:0] exp0, input logic [11:0] step, input int n);
    out_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      chk1("drain_valid", out_valid, 1'b1);
      chk12("drain_data", out_data, exp0 + step * 12'(i));
      chk1("drain_last", out_last, i == 7);
      @(negedge clk);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    enable      = 1'b0;
    out_ready   = 1'b1;
    ch_sel      = 3'd0;
    for (int i = 0; i < 8; i++) ch_in[i] = 12'h000;

    repeat (2) @(negedge clk);
    chk1("rst_valid", out_valid, 1'b0);
    chk1("rst_last", out_last, 1'b0);
    chk12("rst_data", out_data, 12'h000);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_overrun", overrun, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // Ramp on CH2; enable dropped at drain start so no tick lands in DRAIN.
    fill_frame(3'd2, 12'h800, 12'h001, 1'b1);
    enable = 1'b0;
    chk1("ramp_overrun0", overrun, 1'b0);
    drain_frame(12'h000, 12'h001, 8);
    chk1("ramp_idle_valid", out_valid, 1'b0);
    chk1("ramp_idle_busy", busy, 1'b0);
    chk1("ramp_overrun1", overrun, 1'b0);

    // Conversion extremes on CH0 across two back-to-back frames.
    fill_frame(3'd0, 12'h000, 12'h000, 1'b1);
    drain_frame(12'h800, 12'h000, 8);
    chk1("conv_overrun_kept", overrun, 1'b1);
    chk1("conv_refill_busy", busy, 1'b1);
    fill_frame(3'd0, 12'hFFF, 12'h000, 1'b0);
    enable = 1'b0;
    drain_frame(12'h7FF, 12'h000, 8);
    chk1("conv_idle_valid", out_valid, 1'b0);

    // Backpressure: ten stalled cycles at sample 0, ticks during the stall.
    fill_frame(3'd1, 12'h900, 12'h001, 1'b1);
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk1("bp_valid", out_valid, 1'b1);
      chk12("bp_data", out_data, 12'h100);
      chk1("bp_last", out_last, 1'b0);
      @(negedge clk);
    end
    chk1("bp_overrun", overrun, 1'b1);
    enable = 1'b0;
    drain_frame(12'h100, 12'h001, 8);
    chk1("bp_idle_valid", out_valid, 1'b0);

    // Abort after three captures, then a fresh frame (overrun cleared on IDLE->FILL).
    ch_sel   = 3'd3;
    ch_in[3] = 12'hABC;
    for (int c = 0; c < 12; c++) begin
      enable = 1'b1;
      chk1("abort_fill_valid", out_valid, 1'b0);
      @(negedge clk);
    end
    enable = 1'b0;
    @(negedge clk);
    for (int c = 0; c < 4; c++) begin
      chk1("abort_busy", busy, 1'b0);
      chk1("abort_valid", out_valid, 1'b0);
      @(negedge clk);
    end
    fill_frame(3'd3, 12'h820, 12'h001, 1'b1);
    chk1("abort_overrun_clr", overrun, 1'b0);
    enable = 1'b0;
    drain_frame(12'h020, 12'h001, 8);

    // Reset in the middle of a drain, after four transfers.
    fill_frame(3'd4, 12'h840, 12'h001, 1'b1);
    drain_frame(12'h040, 12'h001, 4);
    chk1("mid_overrun", overrun, 1'b1);
    rst    = 1'b1;
    enable = 1'b0;
    #1;
    chk1("mr_valid", out_valid, 1'b0);
    chk1("mr_last", out_last, 1'b0);
    chk12("mr_data", out_data, 12'h000);
    chk1("mr_busy", busy, 1'b0);
    chk1("mr_overrun", overrun, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      chk1("post_rst_valid", out_valid, 1'b0);
      chk1("post_rst_busy", busy, 1'b0);
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
